// File: rtl/puf_crp_harvester.sv
// Challenge driver and response collector for one arbiter PUF level:
// LFSR challenges, arm/settle/sample per bit, majority vote, 32-bit words over valid/ready.
module puf_crp_harvester #(
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned VOTES         = 5,
    parameter logic [31:0] SEED          = 32'hACE1_1234
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [7:0]  n_words,
    input  logic [31:0] seed,
    output logic        busy,
    output logic [31:0] puf_C,
    output logic        puf_clr,
    input  logic        puf_r,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] resp_data,
    output logic [31:0] chal_first,
    output logic [5:0]  unstable_cnt
);

    localparam int unsigned CW        = 8;
    localparam int unsigned VW        = 4;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [2:0] {IDLE, ARM, SETTLE, SAMPLE, DECIDE, OUT} state_t;

    state_t          state, state_nx;
    logic [7:0]      words_left;
    logic [4:0]      bit_idx;
    logic [CW-1:0]   settle_cnt;
    logic [VW-1:0]   vote_cnt;
    logic [VW-1:0]   ones;
    logic            resp_bit_c;
    logic            unstable_c;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ LFSR_TAPS;
        return n;
    endfunction

    // Next-state and vote decision
    always_comb begin
        state_nx   = state;
        resp_bit_c = (ones > VW'(VOTES / 2));
        unstable_c = (ones != '0) && (ones != VW'(VOTES));
        case (state)
            IDLE:    if (start && (n_words != 8'd0)) state_nx = ARM;
            ARM:     state_nx = SETTLE;
            SETTLE:  if (settle_cnt == CW'(SETTLE_CYCLES - 1)) state_nx = SAMPLE;
            SAMPLE:  if (vote_cnt == VW'(VOTES - 1)) state_nx = DECIDE;
            DECIDE:  state_nx = (bit_idx == 5'd31) ? OUT : ARM;
            OUT:     if (out_ready) state_nx = (words_left == 8'd1) ? IDLE : ARM;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) state <= IDLE;
        else      state <= state_nx;
    end

    // Datapath; status outputs are registered copies of the next state
    always_ff @(posedge clk) begin
        if (!clr) begin
            busy         <= 1'b0;
            puf_clr      <= 1'b0;
            out_valid    <= 1'b0;
            puf_C        <= '0;
            resp_data    <= '0;
            chal_first   <= '0;
            unstable_cnt <= '0;
            words_left   <= '0;
            bit_idx      <= '0;
            settle_cnt   <= '0;
            vote_cnt     <= '0;
            ones         <= '0;
        end else begin
            busy      <= (state_nx != IDLE);
            puf_clr   <= (state_nx == ARM);
            out_valid <= (state_nx == OUT);
            case (state)
                IDLE: begin
                    if (state_nx == ARM) begin
                        words_left   <= n_words;
                        puf_C        <= (seed == 32'd0) ? SEED : seed;
                        bit_idx      <= '0;
                        resp_data    <= '0;
                        unstable_cnt <= '0;
                    end
                end
                ARM: begin
                    if (bit_idx == 5'd0) chal_first <= puf_C;
                    settle_cnt <= '0;
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + CW'(1);
                    vote_cnt   <= '0;
                    ones       <= '0;
                end
                SAMPLE: begin
                    vote_cnt <= vote_cnt + VW'(1);
                    ones     <= ones + VW'(puf_r);
                end
                DECIDE: begin
                    resp_data[bit_idx] <= resp_bit_c;
                    if (unstable_c) unstable_cnt <= unstable_cnt + 6'd1;
                    puf_C   <= lfsr_next(puf_C);
                    bit_idx <= bit_idx + 5'd1;
                end
                OUT: begin
                    if (out_ready) begin
                        words_left   <= words_left - 8'd1;
                        bit_idx      <= '0;
                        unstable_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_crp_harvester.sv
// Scoreboard bench for puf_crp_harvester: a PUF model answers challenges,
// expected words are queued at start, and a monitor checks each transfer.
module tb_puf_crp_harvester;

    localparam logic [31:0] SEED  = 32'hACE1_1234;
    localparam logic [31:0] MASK  = 32'h0F0F_3C5A;
    localparam logic [31:0] TAPS  = 32'h8020_0003;

    logic        clk = 1'b0;
    logic        clr, start, puf_r, out_ready;
    logic [7:0]  n_words;
    logic [31:0] seed;
    logic        busy, puf_clr, out_valid;
    logic [31:0] puf_C, resp_data, chal_first;
    logic [5:0]  unstable_cnt;

    typedef struct {
        logic [31:0] resp;
        logic [31:0] chal;
        logic [5:0]  unst;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_xfer   = 0;
    int puf_mode = 0;   // 0: k_ones of the vote cycles high, 1: challenge parity
    int k_ones   = 5;
    int pcnt     = 100;

    always #5 clk = ~clk;

    puf_crp_harvester dut (
        .clk(clk), .clr(clr), .start(start), .n_words(n_words), .seed(seed),
        .busy(busy), .puf_C(puf_C), .puf_clr(puf_clr), .puf_r(puf_r),
        .out_valid(out_valid), .out_ready(out_ready), .resp_data(resp_data),
        .chal_first(chal_first), .unstable_cnt(unstable_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] step(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ TAPS;
        return n;
    endfunction

    function automatic logic [31:0] step_n(input logic [31:0] s, input int n);
        logic [31:0] t;
        t = s;
        for (int i = 0; i < n; i++) t = step(t);
        return t;
    endfunction

    function automatic exp_t par_word(input logic [31:0] s0);
        exp_t e;
        logic [31:0] s;
        s = s0;
        e.resp = '0;
        for (int i = 0; i < 32; i++) begin
            e.resp[i] = ^(s & MASK);
            s = step(s);
        end
        e.chal = s0;
        e.unst = 6'd0;
        return e;
    endfunction

    // PUF model: ARM cycle is pcnt 0, SETTLE 1..8, SAMPLE 9..13; outside SAMPLE it drives 1
    always @(posedge clk) begin
        #3;
        if (puf_clr) pcnt = 0;
        else if (pcnt < 1000) pcnt++;
        if (puf_mode == 1)                puf_r = ^(puf_C & MASK);
        else if (pcnt >= 9 && pcnt <= 13) puf_r = ((pcnt - 9) < k_ones);
        else                              puf_r = 1'b1;
    end

    // Monitor: every transfer pops and checks the oldest expected word
    always @(negedge clk) begin
        if (clr && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_word", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("resp_data", resp_data, e.resp);
                check("chal_first", chal_first, e.chal);
                check("unstable_cnt", 32'(unstable_cnt), 32'(e.unst));
            end
            n_xfer++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start(input logic [7:0] nw, input logic [31:0] sd);
        n_words = nw;
        seed    = sd;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_valid(output int k);
        k = 1;
        while (!out_valid && k < 5000) begin
            tick();
            k++;
        end
        if (!out_valid) check("wait_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle;
        int k;
        k = 0;
        while (busy && k < 5000) begin
            tick();
            k++;
        end
        if (busy) check("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_puf_clr"}, 32'(puf_clr), 32'd0);
        check({tag, "_puf_C"}, puf_C, 32'd0);
        check({tag, "_resp_data"}, resp_data, 32'd0);
        check({tag, "_chal_first"}, chal_first, 32'd0);
        check({tag, "_unstable_cnt"}, 32'(unstable_cnt), 32'd0);
    endtask

    initial begin
        int k;
        int xfer0;
        int npulse;
        logic stable, clr_seen, busy_seen;
        logic [31:0] s_resp, s_chal;
        logic [5:0]  s_unst;
        exp_t e;

        clr = 1'b0; start = 1'b1; n_words = 8'd5; seed = 32'd7; out_ready = 1'b1; puf_r = 1'b0;

        // Reset with start held high
        repeat (3) tick();
        check_all_zero("reset");
        clr = 1'b1; start = 1'b0;
        repeat (3) tick();
        check("idle_after_reset", 32'(busy), 32'd0);

        // Constant response, first-word latency
        puf_mode = 0; k_ones = 5;
        e.resp = 32'hFFFF_FFFF; e.chal = 32'h0000_0001; e.unst = 6'd0;
        q.push_back(e);
        pulse_start(8'd1, 32'h0000_0001);
        check("arm_after_start", 32'(puf_clr), 32'd1);
        wait_valid(k);
        check("first_word_latency", 32'(k), 32'd481);
        tick();
        check("busy_low_after_xfer", 32'(busy), 32'd0);
        check("valid_low_after_xfer", 32'(out_valid), 32'd0);

        // Split votes: 2 of 5 and 3 of 5
        k_ones = 2;
        e.resp = 32'h0000_0000; e.chal = 32'h1234_5678; e.unst = 6'd32;
        q.push_back(e);
        pulse_start(8'd1, 32'h1234_5678);
        wait_idle();
        k_ones = 3;
        e.resp = 32'hFFFF_FFFF; e.chal = 32'h1234_5678; e.unst = 6'd32;
        q.push_back(e);
        pulse_start(8'd1, 32'h1234_5678);
        wait_idle();

        // Zero seed falls back to SEED; LFSR continues into word 2
        puf_mode = 1;
        q.push_back(par_word(SEED));
        q.push_back(par_word(step_n(SEED, 32)));
        pulse_start(8'd2, 32'd0);
        check("seed_default_arm", puf_C, SEED);
        k = 0;
        do begin
            tick();
            k++;
        end while (!puf_clr && k < 40);
        check("second_arm_puf_C", puf_C, 32'h5670_891A);
        wait_idle();

        // Backpressure over a 3-word batch
        out_ready = 1'b0;
        xfer0 = n_xfer;
        q.push_back(par_word(32'hDEAD_BEEF));
        q.push_back(par_word(step_n(32'hDEAD_BEEF, 32)));
        q.push_back(par_word(step_n(32'hDEAD_BEEF, 64)));
        pulse_start(8'd3, 32'hDEAD_BEEF);
        for (int w = 0; w < 3; w++) begin
            wait_valid(k);
            s_resp = resp_data; s_chal = chal_first; s_unst = unstable_cnt;
            stable = 1'b1; clr_seen = 1'b0;
            repeat (100) begin
                tick();
                if (!out_valid || resp_data !== s_resp || chal_first !== s_chal ||
                    unstable_cnt !== s_unst) stable = 1'b0;
                if (puf_clr) clr_seen = 1'b1;
            end
            check("bp_data_stable", 32'(stable), 32'd1);
            check("bp_no_puf_clr", 32'(clr_seen), 32'd0);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check("bp_valid_drops", 32'(out_valid), 32'd0);
        end
        wait_idle();
        check("bp_transfer_count", 32'(n_xfer - xfer0), 32'd3);
        out_ready = 1'b1;

        // n_words == 0 is ignored
        pulse_start(8'd0, 32'h5555_AAAA);
        busy_seen = busy;
        repeat (20) begin
            tick();
            if (busy) busy_seen = 1'b1;
        end
        check("zero_words_ignored", 32'(busy_seen), 32'd0);

        // Reset during SAMPLE of bit 17, then a clean rerun of the same seed
        pulse_start(8'd1, 32'hCAFE_F00D);
        npulse = 1;
        k = 0;
        while (npulse < 18 && k < 1000) begin
            tick();
            k++;
            if (puf_clr) npulse++;
        end
        repeat (10) tick();
        clr = 1'b0;
        tick();
        check_all_zero("midreset");
        clr = 1'b1;
        tick();
        check("idle_after_midreset", 32'(busy), 32'd0);
        q.push_back(par_word(32'hCAFE_F00D));
        pulse_start(8'd1, 32'hCAFE_F00D);
        wait_idle();
        repeat (3) tick();

        check("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
